// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: MSB-first shifter fed through a one-word holding buffer,
// with frame strobes and a wrapping sent-frame counter.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 serial_out,
    output logic                 serial_valid,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frames_sent
);

    localparam int unsigned BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]     hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [CNT_WIDTH-1:0] frames_q, frames_d;

    logic accept;
    logic last_bit;
    logic load_pt;

    assign accept   = load_valid && !hold_full_q;
    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == BW'(WIDTH - 1));
    assign load_pt  = (state_q == IDLE) || last_bit;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            frames_q    <= frames_d;
        end
    end

    // Next state: at a load point the holding buffer wins over a fresh word
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        frames_d    = frames_q;

        if (last_bit) begin
            frames_d = frames_q + CNT_WIDTH'(1);
        end

        if (load_pt) begin
            bit_cnt_d = '0;
            if (hold_full_q) begin
                state_d     = SHIFT;
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else if (accept) begin
                state_d = SHIFT;
                shift_d = data_in;
            end else begin
                state_d = IDLE;
                shift_d = '0;
            end
        end else begin
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (accept) begin
                hold_d      = data_in;
                hold_full_d = 1'b1;
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        load_ready   = !hold_full_q;
        serial_valid = (state_q == SHIFT);
        serial_out   = (state_q == SHIFT) && shift_q[WIDTH-1];
        frame_start  = (state_q == SHIFT) && (bit_cnt_q == '0);
        frame_end    = last_bit;
        busy         = (state_q == SHIFT) || hold_full_q;
        frames_sent  = frames_q;
    end

endmodule
